operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Initiator side of the register-file read interface. It accepts decoded instructions and issues synchronous reads on both register-file read ports, whose data arrives one cycle later. It presents the instruction plus both source-operand values downstream through a valid/ready handshake. It snoops the register-file write port so operands never go stale across same-cycle writes or downstream stalls.

Parameters:
XLEN, 32, data width of register values and of the instruction word
RS1_LSB, 15, bit position of the 5-bit rs1 field in the instruction
RS2_LSB, 20, bit position of the 5-bit rs2 field in the instruction

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction this cycle
in_instr  in  XLEN  instruction word
rf_ra1  out  5  register-file read address 1 (= in_instr rs1 field, combinational)
rf_ra2  out  5  register-file read address 2 (= in_instr rs2 field, combinational)
rf_re1  out  1  register-file read enable 1
rf_re2  out  1  register-file read enable 2
rf_dout1  in  XLEN  register-file read data 1 (registered, holds while re1 low)
rf_dout2  in  XLEN  register-file read data 2
wb_we  in  1  snooped register-file write enable
wb_wa  in  5  snooped register-file write address
wb_din  in  XLEN  snooped register-file write data
out_valid  out  1  operands valid
out_ready  in  1  downstream accepts
out_instr  out  XLEN  held instruction
out_rs1_val  out  XLEN  rs1 value
out_rs2_val  out  XLEN  rs2 value

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-high on reset.
- in_ready = !out_valid | out_ready (combinational; full throughput, single holding stage).
- accept = in_valid & in_ready. rf_re1 = rf_re2 = accept. Register-file reads happen only on accept, so rf_dout holds across stalls.
- Latency: an instruction accepted in cycle N has out_valid=1 and operands correct in cycle N+1.
- out_valid:
  - set on accept;
  - cleared when out_ready & !accept;
  - stays 1 on back-to-back accept with out_ready.
- out_instr loads in_instr on accept and holds otherwise.
- Per-operand override state: fwd_v[k] (1 bit) and fwd_d[k] (XLEN), for k = 1, 2.
  - out_rsk_val = fwd_v[k] ? fwd_d[k] : rf_doutk.
- Override update each cycle, for each k. tgt is the incoming rs field on accept, otherwise the held instruction's rs field:
  - hit = wb_we & (wb_wa != 0) & (wb_wa == tgt).
  - On accept: fwd_v[k] <= hit, fwd_d[k] <= wb_din. This covers the register file returning pre-write data for a same-cycle read/write.
  - While holding (no accept): if hit, fwd_v[k] <= 1 and fwd_d[k] <= wb_din. Otherwise unchanged. A later write therefore wins over an earlier one.
- rs = 0 never matches (x0 reads as 0 from the register file). Writes with wb_wa = 0 are ignored.
- Snooping happens regardless of out_valid. It is harmless when invalid, because override state is reloaded on accept.
- Reset values:
  - out_valid = 0, out_instr = 0;
  - fwd_v[1] = fwd_v[2] = 1 and fwd_d = 0, so out_rs1_val = out_rs2_val = 0;
  - in_ready = 1.
- Reset mid-operation discards the held instruction. in_valid during reset is not accepted (in_ready forced 0 while reset is high).
- The block never back-pressures except through out_ready. There is no combinational path from wb_* to outputs.

Decomposition:
- Shared package: RS1_LSB/RS2_LSB field positions, REG_ADDR_W = 5, XLEN.
- Natural sub-module: operand_bypass. One instance per operand holds fwd_v/fwd_d, hit compare and output mux. The top level holds the handshake and out_instr.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles → out_valid=0, in_ready=1, out_rs1_val=out_rs2_val=0, rf_re1=rf_re2=0.
2. Basic read: x5=0x11, x6=0x22 preloaded; accept instr rs1=5, rs2=6 with out_ready=1 → next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22.
3. Same-cycle write: accept rs1=5 while wb_we=1, wb_wa=5, wb_din=0xAB → next cycle out_rs1_val=0xAB (rf_dout1 old value ignored).
4. Stall with write: out_ready=0 for 3 cycles after accepting rs2=6. Writes x6=0x33 then x6=0x44 during the stall → in_ready=0, rf_re*=0, out_rs2_val=0x44 when out_ready rises.
5. x0 handling: rs1=0, wb_we=1, wb_wa=0, wb_din=0xFF → out_rs1_val=0.
6. Back-to-back and reset: three consecutive accepts with out_ready=1 give one output per cycle in order. Asserting reset while out_valid=1 → out_valid=0 next cycle; the held instruction is never presented.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared field positions and widths for the operand-fetch stage.
package operand_fetch_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_RS1_LSB = 15;
    localparam int DEF_RS2_LSB = 20;
endpackage

// File: rtl/operand_fetch_bypass.sv
// operand_bypass: per-operand override of stale register-file read data by snooped writes.
module operand_bypass
    import operand_fetch_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept_i,
    input  logic [REG_ADDR_W-1:0] rs_new_i,
    input  logic [REG_ADDR_W-1:0] rs_held_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_wa_i,
    input  logic [XLEN-1:0]       wb_din_i,
    input  logic [XLEN-1:0]       rf_dout_i,
    output logic [XLEN-1:0]       val_o
);
    logic                  fwd_v_q, fwd_v_d;
    logic [XLEN-1:0]       fwd_d_q, fwd_d_d;
    logic [REG_ADDR_W-1:0] tgt;
    logic                  hit;

    // On accept the override is reloaded so a write landing with the read wins over the pre-write RF data.
    always_comb begin
        tgt     = accept_i ? rs_new_i : rs_held_i;
        hit     = wb_we_i && (wb_wa_i != '0) && (wb_wa_i == tgt);
        fwd_v_d = accept_i ? hit : (hit | fwd_v_q);
        fwd_d_d = (accept_i | hit) ? wb_din_i : fwd_d_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_v_q <= 1'b1;
            fwd_d_q <= '0;
        end else begin
            fwd_v_q <= fwd_v_d;
            fwd_d_q <= fwd_d_d;
        end
    end

    assign val_o = fwd_v_q ? fwd_d_q : rf_dout_i;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issues register-file reads for accepted instructions and presents instruction plus operands downstream.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RS1_LSB = DEF_RS1_LSB,
    parameter int RS2_LSB = DEF_RS2_LSB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_instr,
    output logic [REG_ADDR_W-1:0] rf_ra1,
    output logic [REG_ADDR_W-1:0] rf_ra2,
    output logic                  rf_re1,
    output logic                  rf_re2,
    input  logic [XLEN-1:0]       rf_dout1,
    input  logic [XLEN-1:0]       rf_dout2,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_wa,
    input  logic [XLEN-1:0]       wb_din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_instr,
    output logic [XLEN-1:0]       out_rs1_val,
    output logic [XLEN-1:0]       out_rs2_val
);
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic            accept;

    always_comb begin
        in_ready    = !reset && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_instr_d = accept ? in_instr : out_instr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign rf_ra1    = in_instr[RS1_LSB +: REG_ADDR_W];
    assign rf_ra2    = in_instr[RS2_LSB +: REG_ADDR_W];
    assign rf_re1    = accept;
    assign rf_re2    = accept;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;

    operand_bypass #(.XLEN(XLEN)) u_byp1 (
        .clk       (clk),
        .reset     (reset),
        .accept_i  (accept),
        .rs_new_i  (in_instr[RS1_LSB +: REG_ADDR_W]),
        .rs_held_i (out_instr_q[RS1_LSB +: REG_ADDR_W]),
        .wb_we_i   (wb_we),
        .wb_wa_i   (wb_wa),
        .wb_din_i  (wb_din),
        .rf_dout_i (rf_dout1),
        .val_o     (out_rs1_val)
    );

    operand_bypass #(.XLEN(XLEN)) u_byp2 (
        .clk       (clk),
        .reset     (reset),
        .accept_i  (accept),
        .rs_new_i  (in_instr[RS2_LSB +: REG_ADDR_W]),
        .rs_held_i (out_instr_q[RS2_LSB +: REG_ADDR_W]),
        .wb_we_i   (wb_we),
        .wb_wa_i   (wb_wa),
        .wb_din_i  (wb_din),
        .rf_dout_i (rf_dout2),
        .val_o     (out_rs2_val)
    );
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench; operands must equal the architectural register file as of the cycle they are presented.
module tb_operand_fetch;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0, in_ready;
    logic [31:0] in_instr = 0;
    logic [4:0]  rf_ra1, rf_ra2;
    logic        rf_re1, rf_re2;
    logic [31:0] rf_dout1 = 0, rf_dout2 = 0;
    logic        wb_we = 0;
    logic [4:0]  wb_wa = 0;
    logic [31:0] wb_din = 0;
    logic        out_valid, out_ready = 0;
    logic [31:0] out_instr, out_rs1_val, out_rs2_val;

    logic [31:0] regs [32] = '{default: 32'h0};
    logic [31:0] q [$];
    int total = 0, bad = 0;

    operand_fetch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_re1(rf_re1), .rf_re2(rf_re2),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .wb_we(wb_we), .wb_wa(wb_wa), .wb_din(wb_din),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
    );

    always #5 clk = ~clk;

    // Register file environment: synchronous reads return pre-write contents; x0 is hardwired.
    always @(posedge clk) begin
        if (wb_we && wb_wa != 0) regs[wb_wa] <= wb_din;
        if (rf_re1) rf_dout1 <= regs[rf_ra1];
        if (rf_re2) rf_dout2 <= regs[rf_ra2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b);
        logic [31:0] w;
        w = $urandom;
        w[19:15] = a;
        w[24:20] = b;
        return w;
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [4:0] wa, input logic [31:0] din);
        reset = r; in_valid = v; in_instr = ins; out_ready = ordy;
        wb_we = we; wb_wa = wa; wb_din = din;
        @(posedge clk);
        #1;
    endtask

    // Monitor: model holding stage is the queue; expected operands come from the model register file.
    always @(negedge clk) begin
        logic        exp_rdy;
        logic [31:0] e;
        if (reset) begin
            chk("in_ready_in_reset", 32'(in_ready), 32'd0);
            chk("rf_re1_in_reset", 32'(rf_re1), 32'd0);
            q.delete();
        end else begin
            exp_rdy = (q.size() == 0) || out_ready;
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rf_re1", 32'(rf_re1), 32'(in_valid && exp_rdy));
            chk("rf_re2", 32'(rf_re2), 32'(in_valid && exp_rdy));
            chk("rf_ra1", 32'(rf_ra1), 32'(in_instr[19:15]));
            chk("rf_ra2", 32'(rf_ra2), 32'(in_instr[24:20]));
            if (q.size() != 0) begin
                e = q[0];
                chk("out_instr", out_instr, e);
                chk("out_rs1_val", out_rs1_val, regs[e[19:15]]);
                chk("out_rs2_val", out_rs2_val, regs[e[24:20]]);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_rdy) q.push_back(in_instr);
        end
    end

    initial begin
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        reset = 0;
        @(negedge clk);
        chk("reset_rs1_val", out_rs1_val, 32'd0);
        chk("reset_rs2_val", out_rs2_val, 32'd0);
        chk("reset_out_instr", out_instr, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        step(0, 0, 0, 1, 1, 5, 32'h11);
        step(0, 0, 0, 1, 1, 6, 32'h22);
        step(0, 1, mk(5, 6), 1, 0, 0, 0);
        step(0, 1, mk(5, 7), 1, 1, 5, 32'hAB);
        step(0, 1, mk(8, 6), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 32'h33);
        step(0, 1, mk(1, 2), 0, 1, 6, 32'h44);
        step(0, 1, mk(1, 2), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, mk(0, 3), 1, 1, 0, 32'hFF);
        step(0, 1, mk(1, 2), 1, 0, 0, 0);
        step(0, 1, mk(3, 4), 1, 1, 3, 32'h5);
        step(0, 1, mk(5, 6), 1, 0, 0, 0);
        step(0, 1, mk(9, 10), 0, 0, 0, 0);
        step(1, 1, mk(11, 12), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step(i % 500 == 499, $urandom_range(0, 9) < 7,
                 mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                 $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom);
        step(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
